// File: rtl/fm_sb_pkg.sv
// Shared definitions for fast-monitoring spy-buffer readout: widths, buffer map,
// scheduler state type and the latched readout request.
package fm_sb_pkg;

  localparam int unsigned SB_MAPPED_N = 29;
  localparam int unsigned SB_N        = SB_MAPPED_N;
  localparam int unsigned AXI_DW      = 32;
  localparam int unsigned MON_DW_MAX  = 256;
  localparam int unsigned WPE_MAX     = MON_DW_MAX / AXI_DW;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned WPE_W       = 4;
  localparam int unsigned SB_W        = $clog2(SB_N);

  // Native data width of each mapped buffer; the last two are the dummy master/slave buffers.
  localparam int unsigned SB_TP_DW [SB_N] = '{
    256, 256, 192, 192, 128, 128, 96, 96, 64, 64,
    64,  48,  48,  40,  40,  32,  32, 200, 200, 160,
    160, 120, 120, 80,  80,  72,  72, 32,  32
  };

  function automatic int unsigned find_ceil(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // AXI words needed to carry one entry of buffer idx.
  function automatic int unsigned sb_wpe(input int unsigned idx);
    return find_ceil(SB_TP_DW[idx], AXI_DW);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWait,
    StShift
  } sched_state_e;

  typedef struct packed {
    logic [SB_W-1:0]   sb;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [WPE_W-1:0]  wpe;
  } fm_sb_rd_req_t;

endpackage

// File: rtl/fm_sb_word_serializer.sv
// Holds one spy-memory entry and emits it least-significant word first as an
// AXI_DW valid/ready stream; the owning FSM decides when it is active.
module fm_sb_word_serializer
  import fm_sb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [MON_DW_MAX-1:0] load_data,
  input  logic [WPE_W-1:0]      wpe,
  input  logic                  active,
  input  logic                  last,
  input  logic                  out_ready,
  output logic [AXI_DW-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  entry_done
);

  localparam int unsigned K_W = $clog2(WPE_MAX);

  logic [MON_DW_MAX-1:0] shreg_q;
  logic [K_W-1:0]        k_q;
  logic                  word_last;
  logic                  hs;

  assign hs        = active & out_ready;
  assign word_last = (WPE_W'(k_q) == (wpe - WPE_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      k_q     <= '0;
    end else if (load) begin
      shreg_q <= load_data;
      k_q     <= '0;
    end else if (hs && !word_last) begin
      k_q <= k_q + K_W'(1);
    end
  end

  // Data is forced to zero outside the active phase so idle outputs stay quiet.
  always_comb begin
    out_data = '0;
    if (active) begin
      out_data = shreg_q[AXI_DW*k_q +: AXI_DW];
    end
  end

  assign out_valid  = active;
  assign out_last   = active & last & word_last;
  assign entry_done = hs & word_last;

endmodule

// File: rtl/fm_sb_readout_sched.sv
// Readout scheduler: accepts one host request, fetches entries from the spy
// memory one at a time and streams them out through the word serializer.
module fm_sb_readout_sched
  import fm_sb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SB_W-1:0]       req_sb,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [WPE_W-1:0]      req_wpe,
  input  logic                  abort,
  output logic                  mem_rd_en,
  output logic [SB_W-1:0]       mem_rd_sb,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [MON_DW_MAX-1:0] mem_rd_data,
  output logic [AXI_DW-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_bad_req
);

  localparam logic [SB_W-1:0]  SB_LIM  = SB_W'(SB_N);
  localparam logic [WPE_W-1:0] WPE_LIM = WPE_W'(WPE_MAX);

  sched_state_e  state_q, state_d;
  fm_sb_rd_req_t req_q, req_d;
  logic          err_q, err_d;
  logic          bad_req;
  logic          entry_done;
  logic          ser_load;
  logic          ser_active;
  logic          last_entry;

  assign bad_req = (req_len == '0) | (req_wpe == '0) | (req_wpe > WPE_LIM) | (req_sb >= SB_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // req_q.addr/len track the current entry and the entries still to send.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            req_d.sb   = req_sb;
            req_d.addr = req_addr;
            req_d.len  = req_len;
            req_d.wpe  = req_wpe;
            state_d    = StFetch;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait:  state_d = StShift;
      StShift: begin
        if (entry_done) begin
          if (last_entry) begin
            state_d = StIdle;
          end else begin
            req_d.addr = req_q.addr + ADDR_W'(1);
            req_d.len  = req_q.len - LEN_W'(1);
            state_d    = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over any same-cycle handshake.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign err_bad_req = err_q;
  assign mem_rd_en   = (state_q == StFetch);
  assign mem_rd_sb   = mem_rd_en ? req_q.sb : '0;
  assign mem_rd_addr = mem_rd_en ? req_q.addr : '0;
  assign ser_load    = (state_q == StWait);
  assign ser_active  = (state_q == StShift);
  assign last_entry  = (req_q.len == LEN_W'(1));

  fm_sb_word_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_data  (mem_rd_data),
    .wpe        (req_q.wpe),
    .active     (ser_active),
    .last       (last_entry),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .entry_done (entry_done)
  );

endmodule
